// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU op codes,
// RV32 opcode/funct fields and the instruction classes the decoder recognises.
package controle_pkg;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        DESVIO     = 3'd5,
        ERRO       = 3'd6
    } estado_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_HALF = 3'b001;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;

    typedef enum logic [2:0] {
        CL_NENHUMA = 3'd0,
        CL_ULA     = 3'd1,
        CL_LOAD    = 3'd2,
        CL_STORE   = 3'd3,
        CL_DESVIO  = 3'd4
    } classe_t;

endpackage

// File: rtl/decodificador_alu.sv
// Combinational decode of the registered IR into ALU control, operand select,
// instruction class and a supported flag.
module decodificador_alu
    import controle_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [3:0]  alu_controle_o,
    output logic        alu_src_o,
    output logic [2:0]  classe_o,
    output logic        suportada_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [14:0] unused_campos;

    assign opcode        = ir_i[6:0];
    assign funct3        = ir_i[14:12];
    assign funct7        = ir_i[31:25];
    assign unused_campos = {ir_i[24:15], ir_i[11:7]};

    always_comb begin
        alu_controle_o = ALU_ADD;
        alu_src_o      = 1'b0;
        classe_o       = CL_NENHUMA;
        unique case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD && funct7 == F7_BASE) begin
                    classe_o = CL_ULA;
                end else if (funct3 == F3_OR) begin
                    alu_controle_o = ALU_OR;
                    classe_o       = CL_ULA;
                end else if (funct3 == F3_SLL && funct7 == F7_BASE) begin
                    alu_controle_o = ALU_SLL;
                    classe_o       = CL_ULA;
                end
            end
            OP_I: begin
                if (funct3 == F3_AND) begin
                    alu_controle_o = ALU_AND;
                    alu_src_o      = 1'b1;
                    classe_o       = CL_ULA;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_HALF) begin
                    alu_src_o = 1'b1;
                    classe_o  = CL_LOAD;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_HALF) begin
                    alu_src_o = 1'b1;
                    classe_o  = CL_STORE;
                end
            end
            OP_BRANCH: begin
                // bne compares by subtraction; the immediate is not an operand
                if (funct3 == F3_BNE) begin
                    alu_controle_o = ALU_SUB;
                    classe_o       = CL_DESVIO;
                end
            end
            default: begin
                classe_o = CL_NENHUMA;
            end
        endcase
    end

    assign suportada_o = (classe_o != CL_NENHUMA);

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: fetch, decode, execute, memory, writeback, branch.
// Define CONTROLE_ERRO_EN to trap unsupported instructions in a sticky ERRO state.
module controle_multiciclo
    import controle_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instrucao,
    input  logic        instr_valida,
    input  logic        resultado_desvio,
    input  logic        mem_pronto,
    output logic [3:0]  alu_controle,
    output logic        alu_src,
    output logic        carrega_ir,
    output logic        escreve_pc,
    output logic        seleciona_pc_desvio,
    output logic        escreve_reg,
    output logic        le_mem,
    output logic        escreve_mem,
    output logic [2:0]  estado,
    output logic        instr_invalida,
    output logic [15:0] instrucoes_concluidas
);

    estado_t     estado_q, estado_d;
    logic [31:0] ir_q, ir_d;
    logic [15:0] concluidas_q, concluidas_d;
    logic        conclui;

    logic [3:0]  dec_alu;
    logic        dec_src;
    logic [2:0]  dec_classe;
    logic        dec_suportada;
    classe_t     classe;

    decodificador_alu u_dec (
        .ir_i           (ir_q),
        .alu_controle_o (dec_alu),
        .alu_src_o      (dec_src),
        .classe_o       (dec_classe),
        .suportada_o    (dec_suportada)
    );

    assign classe = classe_t'(dec_classe);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= BUSCA;
            ir_q         <= '0;
            concluidas_q <= '0;
        end else begin
            estado_q     <= estado_d;
            ir_q         <= ir_d;
            concluidas_q <= concluidas_d;
        end
    end

    always_comb begin
        estado_d            = estado_q;
        ir_d                = ir_q;
        conclui             = 1'b0;
        carrega_ir          = 1'b0;
        escreve_pc          = 1'b0;
        seleciona_pc_desvio = 1'b0;
        escreve_reg         = 1'b0;
        le_mem              = 1'b0;
        escreve_mem         = 1'b0;
        alu_controle        = ALU_ADD;
        alu_src             = 1'b0;
        unique case (estado_q)
            BUSCA: begin
                if (instr_valida) begin
                    carrega_ir = 1'b1;
                    escreve_pc = 1'b1;
                    ir_d       = instrucao;
                    estado_d   = DECODIFICA;
                end
            end
            DECODIFICA: begin
                if (dec_suportada) begin
                    estado_d = EXECUTA;
                end else begin
`ifdef CONTROLE_ERRO_EN
                    estado_d = ERRO;
`else
                    estado_d = BUSCA;
`endif
                end
            end
            EXECUTA: begin
                alu_controle = dec_alu;
                alu_src      = dec_src;
                if (classe == CL_LOAD || classe == CL_STORE) begin
                    estado_d = MEMORIA;
                end else if (classe == CL_DESVIO) begin
                    estado_d = DESVIO;
                end else begin
                    estado_d = ESCRITA;
                end
            end
            MEMORIA: begin
                alu_controle = dec_alu;
                alu_src      = dec_src;
                le_mem       = (classe == CL_LOAD);
                escreve_mem  = (classe == CL_STORE);
                if (mem_pronto) begin
                    if (classe == CL_LOAD) begin
                        estado_d = ESCRITA;
                    end else begin
                        estado_d = BUSCA;
                        conclui  = 1'b1;
                    end
                end
            end
            ESCRITA: begin
                alu_controle = dec_alu;
                alu_src      = dec_src;
                escreve_reg  = 1'b1;
                estado_d     = BUSCA;
                conclui      = 1'b1;
            end
            DESVIO: begin
                alu_controle = dec_alu;
                alu_src      = dec_src;
                // resultado_desvio=1 means equal operands, so bne is not taken
                if (!resultado_desvio) begin
                    escreve_pc          = 1'b1;
                    seleciona_pc_desvio = 1'b1;
                end
                estado_d = BUSCA;
                conclui  = 1'b1;
            end
`ifdef CONTROLE_ERRO_EN
            ERRO: begin
                estado_d = ERRO;
            end
`endif
            default: begin
                estado_d = BUSCA;
            end
        endcase
        concluidas_d = conclui ? concluidas_q + 16'd1 : concluidas_q;
    end

`ifdef CONTROLE_ERRO_EN
    assign instr_invalida = (estado_q == ERRO);
`else
    assign instr_invalida = 1'b0;
`endif

    assign estado                = estado_q;
    assign instrucoes_concluidas = concluidas_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized self-checking bench for controle_multiciclo against a
// per-instruction cycle-trace model built from the instruction rules.
module tb_controle_multiciclo;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instrucao = '0;
    logic        instr_valida = 1'b0;
    logic        resultado_desvio = 1'b0;
    logic        mem_pronto = 1'b0;
    logic [3:0]  alu_controle;
    logic        alu_src;
    logic        carrega_ir;
    logic        escreve_pc;
    logic        seleciona_pc_desvio;
    logic        escreve_reg;
    logic        le_mem;
    logic        escreve_mem;
    logic [2:0]  estado;
    logic        instr_invalida;
    logic [15:0] instrucoes_concluidas;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] model_cnt = '0;

`ifdef CONTROLE_ERRO_EN
    localparam bit ERRO_EN = 1'b1;
`else
    localparam bit ERRO_EN = 1'b0;
`endif

    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [6:0] S_CAR = 7'b1000000;
    localparam logic [6:0] S_PC  = 7'b0100000;
    localparam logic [6:0] S_SEL = 7'b0010000;
    localparam logic [6:0] S_REG = 7'b0001000;
    localparam logic [6:0] S_LE  = 7'b0000100;
    localparam logic [6:0] S_ESC = 7'b0000010;
    localparam logic [6:0] S_INV = 7'b0000001;

    controle_multiciclo dut (
        .clock                 (clock),
        .reset                 (reset),
        .instrucao             (instrucao),
        .instr_valida          (instr_valida),
        .resultado_desvio      (resultado_desvio),
        .mem_pronto            (mem_pronto),
        .alu_controle          (alu_controle),
        .alu_src               (alu_src),
        .carrega_ir            (carrega_ir),
        .escreve_pc            (escreve_pc),
        .seleciona_pc_desvio   (seleciona_pc_desvio),
        .escreve_reg           (escreve_reg),
        .le_mem                (le_mem),
        .escreve_mem           (escreve_mem),
        .estado                (estado),
        .instr_invalida        (instr_invalida),
        .instrucoes_concluidas (instrucoes_concluidas)
    );

    always #5 clock = ~clock;

    logic [14:0] obs;
    assign obs = {estado, alu_controle, alu_src, carrega_ir, escreve_pc,
                  seleciona_pc_desvio, escreve_reg, le_mem, escreve_mem,
                  instr_invalida};

    function automatic logic [14:0] vet(input logic [2:0] e, input logic [3:0] a,
                                        input logic s, input logic [6:0] st);
        return {e, a, s, st};
    endfunction

    // kind: 0 unsupported, 1 alu/writeback, 2 lh, 3 sh, 4 bne
    function automatic void decode_spec(input logic [31:0] ins, output int kind,
                                        output logic [3:0] op, output logic src);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        kind = 0;
        op = 4'b0010;
        src = 1'b0;
        if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'd0) begin
            kind = 1;
        end else if (opc == 7'b0110011 && f3 == 3'b110) begin
            kind = 1; op = 4'b0001;
        end else if (opc == 7'b0110011 && f3 == 3'b001 && f7 == 7'd0) begin
            kind = 1; op = 4'b0011;
        end else if (opc == 7'b0010011 && f3 == 3'b111) begin
            kind = 1; op = 4'b0000; src = 1'b1;
        end else if (opc == 7'b0000011 && f3 == 3'b001) begin
            kind = 2; src = 1'b1;
        end else if (opc == 7'b0100011 && f3 == 3'b001) begin
            kind = 3; src = 1'b1;
        end else if (opc == 7'b1100011 && f3 == 3'b001) begin
            kind = 4; op = 4'b0110;
        end
    endfunction

    function automatic logic [31:0] gen_instr(input int k);
        logic [31:0] ins;
        ins = $urandom;
        case (k)
            0: begin ins[31:25] = 7'd0; ins[14:12] = 3'b000; ins[6:0] = 7'b0110011; end
            1: begin ins[14:12] = 3'b110; ins[6:0] = 7'b0110011; end
            2: begin ins[31:25] = 7'd0; ins[14:12] = 3'b001; ins[6:0] = 7'b0110011; end
            3: begin ins[14:12] = 3'b111; ins[6:0] = 7'b0010011; end
            4: begin ins[14:12] = 3'b001; ins[6:0] = 7'b0000011; end
            5: begin ins[14:12] = 3'b001; ins[6:0] = 7'b0100011; end
            6: begin ins[14:12] = 3'b001; ins[6:0] = 7'b1100011; end
            default: begin
                if ($urandom_range(0, 1) == 1) begin
                    ins[31:25] = 7'b0100000; ins[14:12] = 3'b000; ins[6:0] = 7'b0110011;
                end
            end
        endcase
        return ins;
    endfunction

    task automatic run_instr(input logic [31:0] ins, input int espera, input logic rd);
        int          kind;
        logic [3:0]  op;
        logic        src;
        logic [14:0] q_exp[$];
        logic        q_mp[$];
        int          acc;
        int          desv;
        int          n_idle;
        logic [2:0]  est_fim;
        decode_spec(ins, kind, op, src);
        desv = -1;
        n_idle = $urandom_range(0, 2);
        for (int i = 0; i < n_idle; i++) begin
            q_exp.push_back(vet(3'd0, A_ADD, 1'b0, 7'd0));
            q_mp.push_back(1'($urandom));
        end
        acc = q_exp.size();
        q_exp.push_back(vet(3'd0, A_ADD, 1'b0, S_CAR | S_PC));
        q_mp.push_back(1'($urandom));
        q_exp.push_back(vet(3'd1, A_ADD, 1'b0, 7'd0));
        q_mp.push_back(1'($urandom));
        if (kind == 0) begin
            if (ERRO_EN) begin
                for (int i = 0; i < 3; i++) begin
                    q_exp.push_back(vet(3'd6, A_ADD, 1'b0, S_INV));
                    q_mp.push_back(1'($urandom));
                end
            end
        end else begin
            q_exp.push_back(vet(3'd2, op, src, 7'd0));
            q_mp.push_back(1'($urandom));
            case (kind)
                1: begin
                    q_exp.push_back(vet(3'd4, op, src, S_REG));
                    q_mp.push_back(1'($urandom));
                end
                2, 3: begin
                    for (int j = 0; j <= espera; j++) begin
                        q_exp.push_back(vet(3'd3, op, src, (kind == 2) ? S_LE : S_ESC));
                        q_mp.push_back(j == espera);
                    end
                    if (kind == 2) begin
                        q_exp.push_back(vet(3'd4, op, src, S_REG));
                        q_mp.push_back(1'($urandom));
                    end
                end
                default: begin
                    desv = q_exp.size();
                    q_exp.push_back(vet(3'd5, op, src, rd ? 7'd0 : (S_PC | S_SEL)));
                    q_mp.push_back(1'($urandom));
                end
            endcase
        end
        for (int i = 0; i < q_exp.size(); i++) begin
            @(negedge clock);
            instr_valida = (i == acc) ? 1'b1 : ((i < acc) ? 1'b0 : 1'($urandom));
            instrucao = (i == acc) ? ins : $urandom;
            mem_pronto = q_mp[i];
            resultado_desvio = (i == desv) ? rd : 1'($urandom);
            #1;
            checks++;
            if (obs !== q_exp[i]) begin
                failures++;
                $display("FAIL trace ins=%h step=%0d got=%b want=%b", ins, i, obs, q_exp[i]);
            end
        end
        if (kind != 0) model_cnt = model_cnt + 16'd1;
        @(negedge clock);
        instr_valida = 1'b0;
        mem_pronto = 1'($urandom);
        #1;
        est_fim = (kind == 0 && ERRO_EN) ? 3'd6 : 3'd0;
        checks++;
        if (estado !== est_fim) begin
            failures++;
            $display("FAIL end_state ins=%h got=%0d want=%0d", ins, estado, est_fim);
        end
        checks++;
        if (instrucoes_concluidas !== model_cnt) begin
            failures++;
            $display("FAIL counter ins=%h got=%h want=%h", ins, instrucoes_concluidas, model_cnt);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== vet(3'd0, A_ADD, 1'b0, 7'd0)) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", obs, vet(3'd0, A_ADD, 1'b0, 7'd0));
        end
        checks++;
        if (instrucoes_concluidas !== 16'd0) begin
            failures++;
            $display("FAIL reset_counter got=%h want=0000", instrucoes_concluidas);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        instr_valida = 1'b1;
        instrucao = 32'h002081B3;
        @(negedge clock);
        instr_valida = 1'b0;
        #1;
        checks++;
        if (estado !== 3'd1) begin
            failures++;
            $display("FAIL reset_pre_decode got=%0d want=1", estado);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs !== vet(3'd0, A_ADD, 1'b0, 7'd0)) begin
            failures++;
            $display("FAIL reset_async got=%b want=%b", obs, vet(3'd0, A_ADD, 1'b0, 7'd0));
        end
        @(negedge clock);
        reset = 1'b0;
        model_cnt = '0;
    endtask

    task automatic test_add_exemplo();
        run_instr(32'h002081B3, 0, 1'b0);
    endtask

    task automatic test_lh_espera();
        run_instr(gen_instr(4), 3, 1'b0);
    endtask

    task automatic test_bne();
        run_instr(gen_instr(6), 0, 1'b0);
        run_instr(gen_instr(6), 0, 1'b1);
    endtask

    task automatic test_aleatorio();
        int k;
        for (int n = 0; n < 60; n++) begin
            k = ERRO_EN ? $urandom_range(0, 6) : $urandom_range(0, 7);
            run_instr(gen_instr(k), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    task automatic test_reset_meio_sh();
        @(negedge clock);
        instr_valida = 1'b1;
        instrucao = gen_instr(5);
        mem_pronto = 1'b0;
        @(negedge clock);
        instr_valida = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++;
        if (estado !== 3'd3 || escreve_mem !== 1'b1) begin
            failures++;
            $display("FAIL sh_in_mem got estado=%0d esc=%b want estado=3 esc=1", estado, escreve_mem);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (estado !== 3'd0 || escreve_mem !== 1'b0) begin
            failures++;
            $display("FAIL sh_reset got estado=%0d esc=%b want estado=0 esc=0", estado, escreve_mem);
        end
        @(negedge clock);
        reset = 1'b0;
        model_cnt = '0;
    endtask

    task automatic test_contador_wrap();
        @(negedge clock);
        instr_valida = 1'b0;
        force dut.concluidas_q = 16'hFFFF;
        @(negedge clock);
        @(negedge clock);
        release dut.concluidas_q;
        #1;
        checks++;
        if (instrucoes_concluidas !== 16'hFFFF) begin
            failures++;
            $display("FAIL preset got=%h want=ffff", instrucoes_concluidas);
        end
        model_cnt = 16'hFFFF;
        run_instr(gen_instr($urandom_range(0, 6)), $urandom_range(0, 2), 1'($urandom));
    endtask

    task automatic test_invalida();
        logic [31:0] ins;
        ins = $urandom;
        ins[6:0] = 7'h7F;
        run_instr(ins, 0, 1'b0);
`ifdef CONTROLE_ERRO_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            instr_valida = 1'($urandom);
            mem_pronto = 1'($urandom);
            #1;
            checks++;
            if (estado !== 3'd6 || instr_invalida !== 1'b1) begin
                failures++;
                $display("FAIL erro_sticky got estado=%0d inv=%b", estado, instr_invalida);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (estado !== 3'd0 || instr_invalida !== 1'b0) begin
            failures++;
            $display("FAIL erro_reset got estado=%0d inv=%b", estado, instr_invalida);
        end
        @(negedge clock);
        reset = 1'b0;
        instr_valida = 1'b0;
        model_cnt = '0;
`endif
    endtask

    initial begin
        test_reset();
        test_add_exemplo();
        test_lh_espera();
        test_bne();
        test_aleatorio();
        test_invalida();
        test_reset_meio_sh();
        test_contador_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; all state changes on posedge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; forces the reset state immediately.
REQ-003 SHALL have ports: instrucao  in  32  fetched instruction word; valid when instr_valida=1.
REQ-004 SHALL have ports: instr_valida  in  1  fetch data present.
REQ-005 SHALL have ports: resultado_desvio  in  1  ALU compare flag; 1 = operands equal.
REQ-006 SHALL have ports: mem_pronto  in  1  data-memory access complete.
REQ-007 SHALL have ports: alu_controle  out  4  ALU operation code.
REQ-008 SHALL have ports: alu_src  out  1  1 = second ALU operand is the immediate.
REQ-009 SHALL have ports: carrega_ir, escreve_pc, seleciona_pc_desvio, escreve_reg, le_mem, escreve_mem  out  1 each  datapath strobes.
REQ-010 SHALL have ports: estado  out  3  current FSM state; instr_invalida  out  1; instrucoes_concluidas  out  16.

Function
REQ-011 SHALL encode ALU ops: and=0000, or=0001, add=0010, sll=0011, sub=0110.
REQ-012 SHALL decode, from the registered IR: opcode 0110011 f3 000 f7 0 -> add; f3 110 -> or; f3 001 f7 0 -> sll; 0010011 f3 111 -> andi (and, alu_src=1); 0000011 f3 001 -> lh (add, alu_src=1); 0100011 f3 001 -> sh (add, alu_src=1); 1100011 f3 001 -> bne (sub, alu_src=0); all else unsupported.
REQ-013 SHALL use states BUSCA=0, DECODIFICA=1, EXECUTA=2, MEMORIA=3, ESCRITA=4, DESVIO=5, ERRO=6.
REQ-014 BUSCA: hold while instr_valida=0; when instr_valida=1, assert carrega_ir and escreve_pc (PC+4) that cycle, latch IR, go to DECODIFICA.
REQ-015 DECODIFICA: one cycle; go to EXECUTA if supported, else per REQ-024/025.
REQ-016 EXECUTA: drive alu_controle/alu_src from IR; R/I -> ESCRITA, lh/sh -> MEMORIA, bne -> DESVIO.
REQ-017 alu_controle and alu_src SHALL stay stable from EXECUTA through MEMORIA, ESCRITA and DESVIO; they SHALL be 0010/0 in BUSCA and DECODIFICA.
REQ-018 MEMORIA: lh asserts le_mem, sh asserts escreve_mem, held until the cycle mem_pronto=1; then lh -> ESCRITA, sh -> BUSCA. mem_pronto is ignored in all other states.
REQ-019 ESCRITA: escreve_reg=1 for exactly one cycle -> BUSCA.
REQ-020 DESVIO: sample resultado_desvio; if 0 (taken), assert escreve_pc and seleciona_pc_desvio for one cycle; always -> BUSCA.
REQ-021 instrucoes_concluidas SHALL increment on each return to BUSCA from ESCRITA, MEMORIA or DESVIO, wrapping FFFF -> 0000.
REQ-022 Latency: R/I and bne = 4 cycles from the instr_valida acceptance cycle; lh = 5 plus memory wait; sh = 4 plus memory wait.

Reset
REQ-023 On reset, without waiting for a clock edge: estado=BUSCA, IR=0, instrucoes_concluidas=0, all strobes 0, alu_controle=0010, alu_src=0, instr_invalida=0. Reset mid-access SHALL drop le_mem/escreve_mem immediately.

Configuration
REQ-024 With CONTROLE_ERRO_EN defined: an unsupported instruction SHALL move DECODIFICA -> ERRO; ERRO is sticky until reset, keeps all strobes 0 and holds instr_invalida=1.
REQ-025 Without CONTROLE_ERRO_EN: an unsupported instruction SHALL be a NOP (DECODIFICA -> BUSCA, counter not incremented); the ERRO state is absent and instr_invalida is tied to 0.

Structure
REQ-026 Package controle_pkg SHALL hold the state encodings, ALU op codes, opcode and funct constants, and an instruction-class enum.
REQ-027 Sub-module decodificador_alu (combinational): IR -> alu_controle, alu_src, class, supported flag.

Verification
REQ-028 add x3,x1,x2 (0x002081B3), instr_valida=1 -> estado 0,1,2,4,0; alu_controle=0010; one escreve_reg pulse; counter 0 -> 1.
REQ-029 lh with mem_pronto held low 3 cycles -> le_mem high for 4 cycles in MEMORIA, then ESCRITA, escreve_reg pulse.
REQ-030 bne with resultado_desvio=0 -> DESVIO pulses escreve_pc and seleciona_pc_desvio; with resultado_desvio=1 -> neither strobe asserted, return to BUSCA.
REQ-031 Opcode 0x7F: with CONTROLE_ERRO_EN -> estado=6, instr_invalida=1 until reset; without it -> back to BUSCA, counter unchanged.
REQ-032 Reset asserted mid-MEMORIA for sh -> escreve_mem=0 and estado=0 before the next posedge; counter preset to FFFF -> next completion reads 0000.
